// File: rtl/hdlc_pkg.sv
// Shared HDLC definitions used by both the Tx framer and the Rx deframer.
package hdlc_pkg;
    typedef enum logic [2:0] {IDLE, SFLAG, DATA, FCS, EFLAG, ABORT} tx_state_t;

    localparam logic [7:0]  FLAG     = 8'h7E;
    localparam logic [15:0] FCS_POLY = 16'h8408;
    localparam logic [15:0] FCS_INIT = 16'hFFFF;
    localparam logic [15:0] FCS_GOOD = 16'hF0B8;

    // One bit of reflected CRC-16/X.25.
    function automatic logic [15:0] fcs_step(input logic [15:0] crc, input logic bit_in);
        logic [15:0] shifted;
        shifted = {1'b0, crc[15:1]};
        return (crc[0] ^ bit_in) ? (shifted ^ FCS_POLY) : shifted;
    endfunction
endpackage

// File: rtl/hdlc_fcs16.sv
// Bit-serial CRC-16/X.25 accumulator, one unstuffed bit per enabled cycle.
module hdlc_fcs16
    import hdlc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        enable,
    input  logic        bit_in,
    output logic [15:0] result
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= FCS_INIT;
        end else if (clear) begin
            result <= FCS_INIT;
        end else if (enable) begin
            result <= fcs_step(result, bit_in);
        end
    end
endmodule

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: flags, zero-inserted payload and FCS, abort and idle line.
module hdlc_tx_framer
    import hdlc_pkg::*;
#(
    parameter int FCS_EN     = 1,
    parameter int ABORT_ONES = 8
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_Start,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_DataValid,
    input  logic       Tx_DataLast,
    output logic       Tx_DataReady,
    input  logic       Tx_AbortReq,
    output logic       Tx,
    output logic       Tx_ValidFrame,
    output logic       Tx_Busy,
    output logic       Tx_Done,
    output logic       Tx_AbortedTrans
);
    localparam logic [3:0] ABORT_LAST = 4'(ABORT_ONES - 1);

    tx_state_t   state, state_nxt, load_state;
    logic [3:0]  bit_cnt, bit_cnt_nxt;  // index of the bit now on Tx; wide enough for a 16-bit abort
    logic [2:0]  ones, ones_nxt;
    logic [7:0]  shift, shift_nxt, load_byte;
    logic        last, last_nxt, fcs_hi, fcs_hi_nxt;
    logic        tx_q, tx_nxt, done_q, done_nxt, aborted_q, aborted_nxt;
    logic        fcs_clear, fcs_en, fcs_bit, ready, do_abort, do_load;
    logic [15:0] fcs;

    hdlc_fcs16 u_fcs (
        .clk    (Clk),
        .rst    (Rst),
        .clear  (fcs_clear),
        .enable (fcs_en),
        .bit_in (fcs_bit),
        .result (fcs)
    );

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        ones_nxt    = ones;
        shift_nxt   = shift;
        last_nxt    = last;
        fcs_hi_nxt  = fcs_hi;
        tx_nxt      = 1'b1;
        done_nxt    = 1'b0;
        aborted_nxt = 1'b0;
        fcs_clear   = 1'b0;
        fcs_en      = 1'b0;
        fcs_bit     = 1'b0;
        ready       = 1'b0;
        do_abort    = 1'b0;
        do_load     = 1'b0;
        load_state  = DATA;
        load_byte   = Tx_Data;

        case (state)
            IDLE: begin
                if (Tx_Start) begin
                    state_nxt   = SFLAG;
                    bit_cnt_nxt = '0;
                    ones_nxt    = '0;
                    tx_nxt      = FLAG[0];
                    fcs_clear   = 1'b1;
                end
            end
            SFLAG: begin
                if (Tx_AbortReq) begin
                    do_abort = 1'b1;
                end else if (bit_cnt != 4'd7) begin
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    tx_nxt      = FLAG[bit_cnt_nxt[2:0]];
                end else begin
                    ready    = 1'b1;
                    do_load  = Tx_DataValid;
                    do_abort = !Tx_DataValid;
                end
            end
            DATA, FCS: begin
                // A stuffed zero holds the shift register and bit counter for one cycle.
                if (Tx_AbortReq) begin
                    do_abort = 1'b1;
                end else if (ones == 3'd5) begin
                    tx_nxt   = 1'b0;
                    ones_nxt = '0;
                end else if (bit_cnt != 4'd7) begin
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    shift_nxt   = {1'b0, shift[7:1]};
                    tx_nxt      = shift[1];
                    ones_nxt    = shift[1] ? ones + 3'd1 : 3'd0;
                    fcs_en      = (state == DATA);
                    fcs_bit     = shift[1];
                end else if (state == DATA && !last) begin
                    ready    = 1'b1;
                    do_load  = Tx_DataValid;
                    do_abort = !Tx_DataValid;
                end else if (state == DATA && FCS_EN != 0) begin
                    do_load    = 1'b1;
                    load_state = FCS;
                    load_byte  = ~fcs[7:0];
                    fcs_hi_nxt = 1'b0;
                end else if (state == FCS && !fcs_hi) begin
                    do_load    = 1'b1;
                    load_state = FCS;
                    load_byte  = ~fcs[15:8];
                    fcs_hi_nxt = 1'b1;
                end else begin
                    state_nxt   = EFLAG;
                    bit_cnt_nxt = '0;
                    ones_nxt    = '0;
                    tx_nxt      = FLAG[0];
                end
            end
            EFLAG: begin
                if (bit_cnt != 4'd7) begin
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    tx_nxt      = FLAG[bit_cnt_nxt[2:0]];
                end else begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            ABORT: begin
                if (bit_cnt != ABORT_LAST) begin
                    bit_cnt_nxt = bit_cnt + 4'd1;
                end else begin
                    state_nxt   = IDLE;
                    aborted_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (do_abort) begin
            state_nxt   = ABORT;
            bit_cnt_nxt = '0;
            ones_nxt    = '0;
            tx_nxt      = 1'b0;
        end
        if (do_load) begin
            state_nxt   = load_state;
            shift_nxt   = load_byte;
            bit_cnt_nxt = '0;
            tx_nxt      = load_byte[0];
            ones_nxt    = load_byte[0] ? ones + 3'd1 : 3'd0;
            if (load_state == DATA) begin
                last_nxt = Tx_DataLast;
                fcs_en   = 1'b1;
                fcs_bit  = load_byte[0];
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            ones      <= '0;
            last      <= 1'b0;
            fcs_hi    <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            ones      <= ones_nxt;
            last      <= last_nxt;
            fcs_hi    <= fcs_hi_nxt;
            tx_q      <= tx_nxt;
            done_q    <= done_nxt;
            aborted_q <= aborted_nxt;
        end
    end

    always_ff @(posedge Clk) begin
        shift <= shift_nxt;
    end

    assign Tx              = tx_q;
    assign Tx_DataReady    = ready;
    assign Tx_Busy         = (state != IDLE);
    assign Tx_ValidFrame   = (state != IDLE);
    assign Tx_Done         = done_q;
    assign Tx_AbortedTrans = aborted_q;
endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Directed bench for hdlc_tx_framer: two instances (with and without FCS) scored bit by bit.
module tb_hdlc_tx_framer;
    typedef struct packed {
        logic tx;
        logic vf;
        logic rdy;
        logic done;
        logic ab;
    } exp_t;

    logic       Clk, Rst, Tx_Start, Tx_DataValid, Tx_DataLast, Tx_AbortReq;
    logic [7:0] Tx_Data;
    logic       tx1, vf1, busy1, done1, ab1, rdy1;
    logic       tx0, vf0, busy0, done0, ab0, rdy0;

    int checks = 0;
    int errors = 0;

    exp_t       exp0[$], exp1[$], tq[$];
    logic [7:0] payload[$];
    bit         mq[$], cap_q[$];
    int         data_idx[$], byte_start[$];

    hdlc_tx_framer #(.FCS_EN(1), .ABORT_ONES(8)) dut1 (
        .Clk(Clk), .Rst(Rst), .Tx_Start(Tx_Start), .Tx_Data(Tx_Data),
        .Tx_DataValid(Tx_DataValid), .Tx_DataLast(Tx_DataLast), .Tx_DataReady(rdy1),
        .Tx_AbortReq(Tx_AbortReq), .Tx(tx1), .Tx_ValidFrame(vf1), .Tx_Busy(busy1),
        .Tx_Done(done1), .Tx_AbortedTrans(ab1)
    );

    hdlc_tx_framer #(.FCS_EN(0), .ABORT_ONES(8)) dut0 (
        .Clk(Clk), .Rst(Rst), .Tx_Start(Tx_Start), .Tx_Data(Tx_Data),
        .Tx_DataValid(Tx_DataValid), .Tx_DataLast(Tx_DataLast), .Tx_DataReady(rdy0),
        .Tx_AbortReq(Tx_AbortReq), .Tx(tx0), .Tx_ValidFrame(vf0), .Tx_Busy(busy0),
        .Tx_Done(done0), .Tx_AbortedTrans(ab0)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    function automatic logic [15:0] crc_bit(input logic [15:0] c, input bit d);
        logic fb;
        fb = c[0] ^ d;
        c = c >> 1;
        if (fb) c = c ^ 16'h8408;
        return c;
    endfunction

    task automatic push_stuffed(input bit d, inout int ones);
        mq.push_back(d);
        ones = d ? ones + 1 : 0;
        if (ones == 5) begin
            mq.push_back(1'b0);
            ones = 0;
        end
    endtask

    // Reference serial stream for the current payload.
    task automatic model_frame(input bit fcs_en);
        int          ones;
        logic [15:0] crc, fcs;
        logic [7:0]  flag;
        mq.delete();
        data_idx.delete();
        byte_start.delete();
        flag = 8'h7E;
        ones = 0;
        crc  = 16'hFFFF;
        for (int i = 0; i < 8; i++) mq.push_back(flag[i]);
        for (int b = 0; b < payload.size(); b++) begin
            byte_start.push_back(mq.size());
            for (int i = 0; i < 8; i++) begin
                data_idx.push_back(mq.size());
                crc = crc_bit(crc, payload[b][i]);
                push_stuffed(payload[b][i], ones);
            end
        end
        if (fcs_en) begin
            fcs = ~crc;
            for (int i = 0; i < 16; i++) push_stuffed(fcs[i], ones);
        end
        for (int i = 0; i < 8; i++) mq.push_back(flag[i]);
    endtask

    // Per-cycle expectations; cut >= 0 truncates the stream there and appends an abort.
    task automatic expect_frame(input int cut);
        exp_t e;
        int   lim;
        tq.delete();
        lim = (cut < 0) ? mq.size() : cut;
        for (int i = 0; i < lim; i++) begin
            e = '{tx: mq[i], vf: 1'b1, rdy: 1'b0, done: 1'b0, ab: 1'b0};
            foreach (byte_start[k]) if (byte_start[k] == i + 1) e.rdy = 1'b1;
            tq.push_back(e);
        end
        if (cut < 0) begin
            tq.push_back('{tx: 1'b1, vf: 1'b0, rdy: 1'b0, done: 1'b1, ab: 1'b0});
        end else begin
            tq.push_back('{tx: 1'b0, vf: 1'b1, rdy: 1'b0, done: 1'b0, ab: 1'b0});
            for (int i = 0; i < 7; i++)
                tq.push_back('{tx: 1'b1, vf: 1'b1, rdy: 1'b0, done: 1'b0, ab: 1'b0});
            tq.push_back('{tx: 1'b1, vf: 1'b0, rdy: 1'b0, done: 1'b0, ab: 1'b1});
        end
        tq.push_back('{tx: 1'b1, vf: 1'b0, rdy: 1'b0, done: 1'b0, ab: 1'b0});
    endtask

    task automatic load_both(input int cut);
        model_frame(1'b1);
        expect_frame(cut);
        exp1 = tq;
        model_frame(1'b0);
        expect_frame(cut);
        exp0 = tq;
    endtask

    task automatic run_frame(input int abort_pos, input int starve, input int stray_start,
                             input int late_abort, input int rst_pos, input bit start_abort);
        int   cyc, idx;
        bit   took;
        exp_t e;
        cyc  = 0;
        idx  = 0;
        took = 1'b0;
        cap_q.delete();
        Tx_Data      = payload[0];
        Tx_DataLast  = (payload.size() == 1);
        Tx_DataValid = (starve != 0);
        Tx_Start     = 1'b1;
        Tx_AbortReq  = start_abort;
        @(negedge Clk);
        Tx_Start    = 1'b0;
        Tx_AbortReq = 1'b0;
        while ((exp0.size() > 0 || exp1.size() > 0) && cyc < 2000) begin
            if (took) begin
                idx++;
                if (idx < payload.size()) begin
                    Tx_Data      = payload[idx];
                    Tx_DataLast  = (idx == payload.size() - 1);
                    Tx_DataValid = (idx != starve);
                end else begin
                    Tx_DataValid = 1'b0;
                end
            end
            if (exp1.size() > 0) begin
                e = exp1.pop_front();
                check("f1_tx", tx1, e.tx);
                check("f1_validframe", vf1, e.vf);
                check("f1_busy", busy1, e.vf);
                check("f1_ready", rdy1, e.rdy);
                check("f1_done", done1, e.done);
                check("f1_aborted", ab1, e.ab);
                if (e.vf) cap_q.push_back(tx1);
            end
            if (exp0.size() > 0) begin
                e = exp0.pop_front();
                check("f0_tx", tx0, e.tx);
                check("f0_validframe", vf0, e.vf);
                check("f0_busy", busy0, e.vf);
                check("f0_ready", rdy0, e.rdy);
                check("f0_done", done0, e.done);
                check("f0_aborted", ab0, e.ab);
            end
            took        = rdy1 && Tx_DataValid;
            Tx_AbortReq = (cyc == abort_pos) || (cyc == late_abort);
            Tx_Start    = (cyc == stray_start);
            if (cyc == rst_pos) begin
                #2;
                Rst = 1'b1;
                #1;
                check("rst_tx1", tx1, 1'b1);
                check("rst_tx0", tx0, 1'b1);
                check("rst_busy1", busy1, 1'b0);
                check("rst_validframe1", vf1, 1'b0);
                Tx_AbortReq  = 1'b0;
                Tx_Start     = 1'b0;
                Tx_DataValid = 1'b0;
                repeat (3) @(negedge Clk);
                check("rst_hold_tx1", tx1, 1'b1);
                check("rst_hold_ready1", rdy1, 1'b0);
                Rst = 1'b0;
                exp0.delete();
                exp1.delete();
                @(negedge Clk);
                check("post_rst_tx1", tx1, 1'b1);
                check("post_rst_done1", done1, 1'b0);
                check("post_rst_aborted1", ab1, 1'b0);
                check("post_rst_busy1", busy1, 1'b0);
            end else begin
                @(negedge Clk);
            end
            cyc++;
        end
        Tx_AbortReq  = 1'b0;
        Tx_Start     = 1'b0;
        Tx_DataValid = 1'b0;
        check("frame_in_budget", (cyc < 2000), 1'b1);
    endtask

    // Independent decode of the captured FCS-enabled stream.
    task automatic check_fcs();
        bit          body[$];
        int          ones;
        logic [15:0] crc, fcs;
        ones = 0;
        crc  = 16'hFFFF;
        fcs  = '0;
        for (int i = 8; i < cap_q.size() - 8; i++) begin
            if (ones == 5) begin
                ones = 0;
            end else begin
                body.push_back(cap_q[i]);
                ones = cap_q[i] ? ones + 1 : 0;
            end
        end
        check("fcs_body_len", 16'(body.size()), 16'd88);
        if (body.size() >= 16)
            for (int i = 0; i < 16; i++) fcs[i] = body[body.size() - 16 + i];
        check("fcs_value", fcs, 16'h906E);
        foreach (body[i]) crc = crc_bit(crc, body[i]);
        check("fcs_residual", crc, 16'hF0B8);
    endtask

    initial begin
        int ap, n1;
        Rst          = 1'b1;
        Tx_Start     = 1'b0;
        Tx_Data      = 8'h00;
        Tx_DataValid = 1'b0;
        Tx_DataLast  = 1'b0;
        Tx_AbortReq  = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset_tx", tx1, 1'b1);
        check("reset_ready", rdy1, 1'b0);
        check("reset_busy", busy1, 1'b0);
        check("reset_validframe", vf1, 1'b0);
        check("reset_done", done1, 1'b0);
        check("reset_aborted", ab1, 1'b0);
        check("reset_tx_nofcs", tx0, 1'b0 ^ 1'b1);
        Rst = 1'b0;

        // Idle line with abort requests ignored in IDLE.
        for (int i = 0; i < 50; i++) begin
            Tx_AbortReq = (i == 10);
            @(negedge Clk);
            check("idle_tx", tx1, 1'b1);
            check("idle_validframe", vf1, 1'b0);
            check("idle_tx_nofcs", tx0, 1'b1);
            check("idle_validframe_nofcs", vf0, 1'b0);
        end
        Tx_AbortReq = 1'b0;

        // Single 0xFF byte; Start and AbortReq together in IDLE.
        payload.delete();
        payload.push_back(8'hFF);
        load_both(-1);
        run_frame(-1, -1, -1, -1, -1, 1'b1);

        // "123456789": stray Start while busy, AbortReq during the closing flag.
        payload.delete();
        for (int i = 0; i < 9; i++) payload.push_back(8'h31 + 8'(i));
        model_frame(1'b1);
        n1 = mq.size();
        load_both(-1);
        run_frame(-1, -1, 20, n1 - 4, -1, 1'b0);
        check_fcs();

        // Abort on the third bit of byte 2.
        payload.delete();
        payload.push_back(8'hA5);
        payload.push_back(8'h3C);
        payload.push_back(8'h81);
        model_frame(1'b1);
        ap = data_idx[10];
        load_both(ap + 1);
        run_frame(ap, -1, -1, -1, -1, 1'b0);

        // Underrun at the second ready; byte 1 ends in five ones so ready follows a stuffed 0.
        payload.delete();
        payload.push_back(8'hF8);
        payload.push_back(8'h12);
        payload.push_back(8'h34);
        model_frame(1'b1);
        ap = byte_start[1];
        load_both(ap);
        run_frame(-1, 1, -1, -1, -1, 1'b0);

        // Reset in mid-DATA, then a fresh frame.
        payload.delete();
        payload.push_back(8'hC3);
        payload.push_back(8'h7E);
        payload.push_back(8'hFF);
        payload.push_back(8'h00);
        load_both(-1);
        run_frame(-1, -1, -1, -1, 14, 1'b0);
        payload.delete();
        payload.push_back(8'h7E);
        payload.push_back(8'hFF);
        payload.push_back(8'h0F);
        load_both(-1);
        run_frame(-1, -1, -1, -1, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
